// File: rtl/audio_axis_i2s_tx.sv
// Stereo AXI-Stream to Philips I2S serializer holding one L/R frame; BCLK/LRCK divided from clk.
// Define AUDIO_I2S_UNDERRUN_HOLD_EN to replay the last played frame on underrun instead of silence.
module audio_axis_i2s_tx #(
  parameter int AUDIO_DW       = 32,
  parameter int AUDIO_BIT_RATE = 24,
  parameter int SLOT_BITS      = 32,
  parameter int BCLK_DIV       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AUDIO_DW-1:0] s_axis_data,
  input  logic                s_axis_valid,
  input  logic                s_axis_last,
  output logic                s_axis_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                underrun,
  output logic                frame_error
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);

  typedef enum logic [1:0] {WANT_L = 2'd0, WANT_R = 2'd1, FULL = 2'd2} in_state_e;

  in_state_e                 state_q, state_d;
  logic [DIV_W-1:0]          div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]          bit_cnt, bit_cnt_nxt;
  logic                      div_wrap, boundary, load_full, accept;
  logic                      first_frame_q, frame_err_d, underrun_d;
  logic [AUDIO_BIT_RATE-1:0] sample, left_q, right_q, left_d, right_d;
  logic [FRAME_BITS-1:0]     shift_q, idle_frame, load_frame;
  logic                      unused_upper;

  function automatic logic [SLOT_BITS-1:0] to_slot(input logic [AUDIO_BIT_RATE-1:0] s);
    logic [SLOT_BITS-1:0] r;
    r = '0;
    r[SLOT_BITS-1 -: AUDIO_BIT_RATE] = s;
    return r;
  endfunction

  // Valid/ready: a word transfers on the rising clk edge where s_axis_valid && s_axis_ready
  // are both high; the source keeps data/last stable while valid is high and ready is low.
  assign s_axis_ready = (state_q != FULL) && !reset;
  assign accept       = s_axis_valid && s_axis_ready;
  assign sample       = s_axis_data[AUDIO_BIT_RATE-1:0];
  assign unused_upper = |(s_axis_data >> AUDIO_BIT_RATE);

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign boundary  = div_wrap && (bit_cnt == BIT_LAST);
  assign load_full = boundary && (state_q == FULL);

  always_comb begin
    div_cnt_nxt = div_wrap ? '0 : div_cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    if (div_wrap) bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    frame_err_d = 1'b0;
    case (state_q)
      WANT_L: if (accept) begin
        if (s_axis_last) frame_err_d = 1'b1;
        else begin
          left_d  = sample;
          state_d = WANT_R;
        end
      end
      WANT_R: if (accept) begin
        if (s_axis_last) begin
          right_d = sample;
          state_d = FULL;
        end else begin
          // A second left word resyncs: the newest one wins.
          left_d      = sample;
          frame_err_d = 1'b1;
        end
      end
      FULL:    if (boundary) state_d = WANT_L;
      default: state_d = WANT_L;
    endcase
  end

  // The silent frame right after reset is not an underrun.
  assign underrun_d = boundary && (state_q != FULL) && !first_frame_q;

`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
  logic [AUDIO_BIT_RATE-1:0] played_l_q, played_r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      played_l_q <= '0;
      played_r_q <= '0;
    end else if (load_full) begin
      played_l_q <= left_q;
      played_r_q <= right_q;
    end
  end

  assign idle_frame = {to_slot(played_l_q), to_slot(played_r_q)};
`else
  assign idle_frame = '0;
`endif

  assign load_frame = load_full ? {to_slot(left_q), to_slot(right_q)} : idle_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WANT_L;
      left_q        <= '0;
      right_q       <= '0;
      first_frame_q <= 1'b1;
      underrun      <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      underrun    <= underrun_d;
      frame_error <= frame_err_d;
      if (boundary) first_frame_q <= 1'b0;
    end
  end

  // SDATA takes the shift MSB at every BCLK fall, which yields the one-bit I2S delay:
  // at the boundary the last right bit goes out while the next frame is loaded behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      i2s_bclk <= (div_cnt_nxt >= DIV_HALF);
      if (div_wrap) begin
        i2s_sdata <= shift_q[FRAME_BITS-1];
        i2s_lrck  <= (bit_cnt_nxt >= SLOT_START);
        shift_q   <= boundary ? load_frame : (shift_q << 1);
      end
    end
  end

endmodule

// File: tb/tb_audio_axis_i2s_tx.sv
// Directed bench for audio_axis_i2s_tx at default parameters: frame capture, handshake,
// underrun/frame_error pulses, boundary collision and mid-frame reset.
module tb_audio_axis_i2s_tx;

  localparam logic [31:0] A_L  = 32'h00ABCDEF, A_R = 32'h00123456;
  localparam logic [31:0] B_L  = 32'hFF800001, B_R = 32'h007FFFFE;
  localparam logic [31:0] C_L  = 32'h00C0FFEE, C_R = 32'h00000001;
  localparam logic [31:0] E_L1 = 32'h00AAAAAA, E_L2 = 32'h00555555, E_R = 32'h00F0F0F0;
  localparam logic [31:0] F_L  = 32'h00FEDCBA, F_R = 32'h00654321;
  localparam logic [63:0] LRCK_PATTERN = 64'h00000000_FFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun, frame_error;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          ur_cnt = 0;
  int          fe_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cap_q[$];
  logic [63:0] lr_q[$];
  logic [63:0] sd_acc = '0;
  logic [63:0] lr_acc = '0;
  logic [5:0]  slot_pos;
  logic        prev_bit;

  audio_axis_i2s_tx dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun),
    .frame_error  (frame_error)
  );

  // Clock and a timeline counter: cyc = number of rising edges since reset released.
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: counts pulses and captures SDATA/LRCK mid-way through each BCLK period.
  assign slot_pos = 6'd63 - 6'(cyc[7:2]);

  always @(negedge clk) begin
    if (!reset) begin
      if (underrun)    ur_cnt <= ur_cnt + 1;
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (cyc[1:0] == 2'd2) begin
        sd_acc[slot_pos] <= i2s_sdata;
        lr_acc[slot_pos] <= i2s_lrck;
        if (slot_pos == 6'd0) begin
          cap_q.push_back({sd_acc[63:1], i2s_sdata});
          lr_q.push_back({lr_acc[63:1], i2s_lrck});
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [31:0] l, input logic [31:0] r);
    return {l[23:0], 8'h00, r[23:0], 8'h00};
  endfunction

  task automatic wait_cyc(input int k);
    do @(negedge clk); while (cyc < k);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int waited;
    waited = 0;
    @(negedge clk);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    while (!s_axis_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("send_accept", 64'(s_axis_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected frames, in capture order: 8 before the mid-frame reset, 2 after it.
    exp_q.push_back(64'd0);
    exp_q.push_back(frame_bits(A_L, A_R));
    exp_q.push_back(frame_bits(B_L, B_R));
    exp_q.push_back(frame_bits(C_L, C_R));
`ifdef AUDIO_I2S_UNDERRUN_HOLD_EN
    exp_q.push_back(frame_bits(C_L, C_R));
    exp_q.push_back(frame_bits(E_L2, E_R));
    exp_q.push_back(frame_bits(E_L2, E_R));
`else
    exp_q.push_back(64'd0);
    exp_q.push_back(frame_bits(E_L2, E_R));
    exp_q.push_back(64'd0);
`endif
    exp_q.push_back(frame_bits(F_L, F_R));
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(s_axis_ready), 64'd0);
    check_eq("rst_bclk", 64'(i2s_bclk), 64'd0);
    check_eq("rst_lrck", 64'(i2s_lrck), 64'd0);
    check_eq("rst_sdata", 64'(i2s_sdata), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
    check_eq("rst_frame_error", 64'(frame_error), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_release", 64'(s_axis_ready), 64'd1);

    // Frame A, then ready must stay low until the first boundary at cyc 256.
    send_word(A_L, 1'b0);
    send_word(A_R, 1'b1);
    drop_valid();
    check_eq("ready_low_after_right", 64'(s_axis_ready), 64'd0);
    wait_cyc(255);
    check_eq("ready_low_pre_boundary", 64'(s_axis_ready), 64'd0);
    wait_cyc(256);
    check_eq("ready_high_post_boundary", 64'(s_axis_ready), 64'd1);
    check_eq("no_underrun_first_load", 64'(underrun), 64'd0);

    // Frames B and C back-to-back; C's left word waits with valid high.
    send_word(B_L, 1'b0);
    send_word(B_R, 1'b1);
    drop_valid();
    fork
      begin
        send_word(C_L, 1'b0);
        send_word(C_R, 1'b1);
        drop_valid();
      end
      begin
        wait_cyc(511);
        check_eq("ready_low_b_buffered", 64'(s_axis_ready), 64'd0);
        wait_cyc(512);
        check_eq("ready_high_b_loaded", 64'(s_axis_ready), 64'd1);
      end
    join

    wait_cyc(1023);
    check_eq("no_underrun_streaming", 64'(ur_cnt), 64'd0);
    wait_cyc(1024);
    check_eq("underrun_pulse", 64'(underrun), 64'd1);
    wait_cyc(1025);
    check_eq("underrun_one_clk", 64'(underrun), 64'd0);

    // Misplaced last: dropped in WANT_L, resync on a repeated left word.
    wait_cyc(1030);
    send_word(32'h00DEAD01, 1'b1);
    drop_valid();
    check_eq("fe_last_on_left", 64'(frame_error), 64'd1);
    check_eq("ready_stays_want_l", 64'(s_axis_ready), 64'd1);
    send_word(E_L1, 1'b0);
    send_word(E_L2, 1'b0);
    drop_valid();
    check_eq("fe_repeated_left", 64'(frame_error), 64'd1);
    send_word(E_R, 1'b1);
    drop_valid();
    check_eq("no_fe_on_right", 64'(frame_error), 64'd0);
    check_eq("ready_low_e_buffered", 64'(s_axis_ready), 64'd0);

    // Right word accepted exactly in the boundary clk (edge 1536).
    wait_cyc(1400);
    send_word(F_L, 1'b0);
    drop_valid();
    wait_cyc(1535);
    s_axis_valid = 1'b1;
    s_axis_data  = F_R;
    s_axis_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    check_eq("underrun_on_collision", 64'(underrun), 64'd1);
    check_eq("ready_low_after_collision", 64'(s_axis_ready), 64'd0);
    wait_cyc(1791);
    check_eq("ready_low_until_f_plays", 64'(s_axis_ready), 64'd0);
    wait_cyc(1792);
    check_eq("ready_high_f_loaded", 64'(s_axis_ready), 64'd1);
    check_eq("no_underrun_f_loaded", 64'(underrun), 64'd0);
    check_eq("underrun_count_2", 64'(ur_cnt), 64'd2);
    check_eq("frame_error_count", 64'(fe_cnt), 64'd2);
    wait_cyc(2048);
    check_eq("underrun_after_f", 64'(underrun), 64'd1);

    // Mid-frame reset with BCLK and LRCK both high.
    wait_cyc(2210);
    check_eq("bclk_high_before_reset", 64'(i2s_bclk), 64'd1);
    check_eq("lrck_high_before_reset", 64'(i2s_lrck), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_bclk", 64'(i2s_bclk), 64'd0);
    check_eq("midrst_lrck", 64'(i2s_lrck), 64'd0);
    check_eq("midrst_sdata", 64'(i2s_sdata), 64'd0);
    check_eq("midrst_ready", 64'(s_axis_ready), 64'd0);
    check_eq("midrst_underrun", 64'(underrun), 64'd0);
    check_eq("midrst_frame_error", 64'(frame_error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(1);
    check_eq("bclk_low_restart", 64'(i2s_bclk), 64'd0);
    wait_cyc(2);
    check_eq("bclk_high_restart", 64'(i2s_bclk), 64'd1);
    wait_cyc(130);
    check_eq("lrck_right_restart", 64'(i2s_lrck), 64'd1);
    wait_cyc(256);
    check_eq("no_underrun_first_boundary", 64'(underrun), 64'd0);
    check_eq("underrun_count_3", 64'(ur_cnt), 64'd3);
    wait_cyc(512);
    check_eq("underrun_second_boundary", 64'(underrun), 64'd1);
    wait_cyc(520);

    // Scoreboard: each BCLK period n carries stream bit n-1, period 0 the previous frame's last bit.
    check_eq("frames_captured", 64'(cap_q.size()), 64'(exp_q.size()));
    prev_bit = 1'b0;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check_eq($sformatf("sdata_frame%0d", i), cap_q[i], {prev_bit, exp_q[i][63:1]});
      check_eq($sformatf("lrck_frame%0d", i), lr_q[i], LRCK_PATTERN);
      prev_bit = exp_q[i][0];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
